// File: rtl/alu_op_scheduler_pkg.sv
// Shared state encodings, ALU input-select codes and default widths for the
// ALU operation scheduler.
package alu_op_scheduler_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OP_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        EXEC = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam logic [2:0] SEL_PERSIST = 3'b100;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_RESET   = 3'b001;

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Requester-side bundle: two valid/ready request channels and their result strobes.
interface alu_op_scheduler_if
    import alu_op_scheduler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OP_W  = DEF_OP_W
);
    logic             req0_valid;
    logic             req0_ready;
    logic [OP_W-1:0]  req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [OP_W-1:0]  req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp0_valid;
    logic             rsp0_err;
    logic [WIDTH-1:0] rsp0_data;
    logic             rsp1_valid;
    logic             rsp1_err;
    logic [WIDTH-1:0] rsp1_data;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_err, rsp0_data,
        input  rsp1_valid, rsp1_err, rsp1_data
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_err, rsp0_data,
        output rsp1_valid, rsp1_err, rsp1_data
    );

endinterface

// File: rtl/alu_op_scheduler_rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers who was served last and
// only advances when a grant is actually offered.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       valid0,
    input  logic       valid1,
    output logic [1:0] grant,
    output logic       grant_id
);
    logic last_grant_r;
    logic pick_s;
    logic any_s;

    assign any_s    = valid0 | valid1;
    assign grant_id = pick_s;

    // A tie goes to the requester that was not served last
    always_comb begin
        pick_s = 1'b0;
        if (valid0 && valid1) begin
            pick_s = ~last_grant_r;
        end else if (valid1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // One-hot grant, offered only while the scheduler can accept
    always_comb begin
        grant = 2'b00;
        if (enable && any_s) begin
            grant = pick_s ? 2'b10 : 2'b01;
        end else begin
            grant = 2'b00;
        end
    end

    // Pointer register, updated on every accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= 1'b1;
        end else if (enable && any_s) begin
            last_grant_r <= pick_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Time-shares one ALU between two requesters: arbitrate, load, wait ALU_LAT
// cycles, capture the result and strobe it back on the issuing port.
module alu_op_scheduler
    import alu_op_scheduler_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int OP_W    = DEF_OP_W,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_op_scheduler_if.slave bus,
    output logic [2:0]        alu_in_sel,
    output logic [OP_W-1:0]   alu_out_sel,
    output logic [WIDTH-1:0]  alu_num1,
    output logic [WIDTH-1:0]  alu_num2,
    input  logic [WIDTH-1:0]  alu_out,
    output logic [1:0]        curr_state,
    output logic              busy
);
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

    state_e           state_r, state_s;
    logic [2:0]       in_sel_r, in_sel_s;
    logic [OP_W-1:0]  out_sel_r, out_sel_s;
    logic [WIDTH-1:0] num1_r, num1_s, num2_r, num2_s;
    logic [1:0]       rsp_valid_r, rsp_valid_s, rsp_err_r, rsp_err_s;
    logic [WIDTH-1:0] rsp_data0_r, rsp_data0_s, rsp_data1_r, rsp_data1_s;
    logic             gid_r, gid_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       grant_s;
    logic             grant_id_s, arb_en_s, accept_s;
    logic [OP_W-1:0]  sel_op_s;
    logic [WIDTH-1:0] sel_a_s, sel_b_s;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (arb_en_s),
        .valid0   (bus.req0_valid),
        .valid1   (bus.req1_valid),
        .grant    (grant_s),
        .grant_id (grant_id_s)
    );

    assign arb_en_s       = reset_n && (state_r == IDLE);
    assign accept_s       = |grant_s;
    assign bus.req0_ready = grant_s[0];
    assign bus.req1_ready = grant_s[1];
    assign sel_op_s       = grant_id_s ? bus.req1_op : bus.req0_op;
    assign sel_a_s        = grant_id_s ? bus.req1_a  : bus.req0_a;
    assign sel_b_s        = grant_id_s ? bus.req1_b  : bus.req0_b;

    // Next state and next values of every registered output
    always_comb begin
        state_s     = state_r;
        in_sel_s    = in_sel_r;
        out_sel_s   = out_sel_r;
        num1_s      = num1_r;
        num2_s      = num2_r;
        rsp_valid_s = 2'b00;
        rsp_err_s   = 2'b00;
        rsp_data0_s = rsp_data0_r;
        rsp_data1_s = rsp_data1_r;
        gid_s       = gid_r;
        cnt_s       = cnt_r;
        case (state_r)
            IDLE: begin
                in_sel_s = SEL_PERSIST;
                if (accept_s) begin
                    gid_s = grant_id_s;
                    if ($onehot(sel_op_s)) begin
                        state_s   = LOAD;
                        in_sel_s  = SEL_LOAD;
                        out_sel_s = sel_op_s;
                        num1_s    = sel_a_s;
                        num2_s    = sel_b_s;
                    end else begin
                        // malformed op never touches the ALU
                        state_s                = DONE;
                        rsp_valid_s[grant_id_s] = 1'b1;
                        rsp_err_s[grant_id_s]   = 1'b1;
                        if (grant_id_s) begin
                            rsp_data1_s = {WIDTH{1'b0}};
                        end else begin
                            rsp_data0_s = {WIDTH{1'b0}};
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                state_s  = EXEC;
                in_sel_s = SEL_PERSIST;
                cnt_s    = {CNT_W{1'b0}};
            end
            EXEC: begin
                in_sel_s = SEL_PERSIST;
                if (cnt_r == CNT_LAST) begin
                    state_s           = DONE;
                    out_sel_s         = {OP_W{1'b0}};
                    rsp_valid_s[gid_r] = 1'b1;
                    if (gid_r) begin
                        rsp_data1_s = alu_out;
                    end else begin
                        rsp_data0_s = alu_out;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_s  = IDLE;
                in_sel_s = SEL_PERSIST;
            end
            default: begin
                state_s  = IDLE;
                in_sel_s = SEL_PERSIST;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            in_sel_r    <= SEL_RESET;
            out_sel_r   <= {OP_W{1'b0}};
            num1_r      <= {WIDTH{1'b0}};
            num2_r      <= {WIDTH{1'b0}};
            rsp_valid_r <= 2'b00;
            rsp_err_r   <= 2'b00;
            rsp_data0_r <= {WIDTH{1'b0}};
            rsp_data1_r <= {WIDTH{1'b0}};
            gid_r       <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            in_sel_r    <= in_sel_s;
            out_sel_r   <= out_sel_s;
            num1_r      <= num1_s;
            num2_r      <= num2_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
            rsp_data0_r <= rsp_data0_s;
            rsp_data1_r <= rsp_data1_s;
            gid_r       <= gid_s;
            cnt_r       <= cnt_s;
        end
    end

    assign alu_in_sel     = in_sel_r;
    assign alu_out_sel    = out_sel_r;
    assign alu_num1       = num1_r;
    assign alu_num2       = num2_r;
    assign curr_state     = state_r;
    assign busy           = (state_r != IDLE);
    assign bus.rsp0_valid = rsp_valid_r[0];
    assign bus.rsp1_valid = rsp_valid_r[1];
    assign bus.rsp0_err   = rsp_err_r[0];
    assign bus.rsp1_err   = rsp_err_r[1];
    assign bus.rsp0_data  = rsp_data0_r;
    assign bus.rsp1_data  = rsp_data1_r;

endmodule
